seg7_scan_decoder: RTL and testbench

Observes a multiplexed 7-segment display bus: active-low segment lines plus active-low one-hot digit enables. Recovers the BCD value shown on each digit position. Each captured digit is held in a register bank with valid, blank and error status. The block sits on the display side of the queue-number path as the readback/self-check end: it proves that the digits driven to the panel match the digits the counter logic intended.

---
 rtl/seg7_scan_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: watches a multiplexed active-low 7-segment bus and recovers
// the BCD digit shown at each position, with valid/blank/error status per position.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    seg_a,
    input  logic                    seg_b,
    input  logic                    seg_c,
    input  logic                    seg_d,
    input  logic                    seg_e,
    input  logic                    seg_f,
    input  logic                    seg_g,
    input  logic [NUM_DIGITS-1:0]   dig_en_n,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    upd_stb,
    output logic [2:0]              upd_idx,
    output logic                    err_stb
);
    localparam int         SW         = 7 + NUM_DIGITS;
    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COUNT   = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    logic [SW-1:0] sync1_reg, sync2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, dig_en_n};
            sync2_reg <= sync1_reg;
        end
    end

    // Sample and candidate are both kept as {lit a..g, active-high enables}.
    logic [SW-1:0]         sample;
    logic [NUM_DIGITS-1:0] sample_en;
    logic                  sample_one_hot;

    assign sample         = ~sync2_reg;
    assign sample_en      = sample[NUM_DIGITS-1:0];
    assign sample_one_hot = (sample_en != '0) &&
                            ((sample_en & (sample_en - NUM_DIGITS'(1))) == '0);

    logic [1:0]    state_reg, state_next;
    logic [7:0]    cnt_reg, cnt_next;
    logic [SW-1:0] cand_reg, cand_next;
    logic          capture;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cand_next  = cand_reg;
        capture    = 1'b0;
        case (state_reg)
            ST_COUNT: begin
                if (sample == cand_reg) begin
                    if (cnt_reg != 8'hFF)
                        cnt_next = cnt_reg + 8'd1;
                    if (cnt_reg == STABLE_CNT) begin
                        capture    = 1'b1;
                        state_next = ST_HELD;
                    end
                end else if (sample_one_hot) begin
                    cand_next = sample;
                    cnt_next  = 8'd1;
                end else begin
                    state_next = ST_IDLE;
                    cnt_next   = 8'd0;
                end
            end
            ST_HELD: begin
                if (sample != cand_reg) begin
                    if (sample_one_hot) begin
                        state_next = ST_COUNT;
                        cand_next  = sample;
                        cnt_next   = 8'd1;
                    end else begin
                        state_next = ST_IDLE;
                        cnt_next   = 8'd0;
                    end
                end else if (cnt_reg != 8'hFF) begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: begin
                cnt_next = 8'd0;
                if (sample_one_hot) begin
                    state_next = ST_COUNT;
                    cand_next  = sample;
                    cnt_next   = 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 8'd0;
            cand_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cand_reg  <= cand_next;
        end
    end

    // Returns {blank, illegal, value}.
    function automatic logic [5:0] decode_lit(input logic [6:0] lit);
        case (lit)
            7'b1111110: decode_lit = {2'b00, 4'd0};
            7'b0110000: decode_lit = {2'b00, 4'd1};
            7'b1101101: decode_lit = {2'b00, 4'd2};
            7'b1111001: decode_lit = {2'b00, 4'd3};
            7'b0110011: decode_lit = {2'b00, 4'd4};
            7'b1011011: decode_lit = {2'b00, 4'd5};
            7'b1011111: decode_lit = {2'b00, 4'd6};
            7'b1110000: decode_lit = {2'b00, 4'd7};
            7'b1111111: decode_lit = {2'b00, 4'd8};
            7'b1111011: decode_lit = {2'b00, 4'd9};
            7'b0000000: decode_lit = {2'b10, 4'hF};
            default:    decode_lit = {2'b01, 4'h0};
        endcase
    endfunction

    logic [NUM_DIGITS-1:0] cand_en;
    logic [5:0]            cap_dec;
    logic                  cap_blank, cap_illegal;
    logic [3:0]            cap_value;
    logic [2:0]            cap_idx;

    assign cand_en     = cand_reg[NUM_DIGITS-1:0];
    assign cap_dec     = decode_lit(cand_reg[SW-1:NUM_DIGITS]);
    assign cap_blank   = cap_dec[5];
    assign cap_illegal = cap_dec[4];
    assign cap_value   = cap_dec[3:0];

    always_comb begin
        cap_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (cand_en[i])
                cap_idx = 3'(i);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_pos
            logic [3:0] val_reg;
            logic       valid_reg, blank_reg, err_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    val_reg   <= 4'hF;
                    valid_reg <= 1'b0;
                    blank_reg <= 1'b0;
                    err_reg   <= 1'b0;
                end else if (capture && cand_en[gi]) begin
                    if (cap_illegal) begin
                        err_reg   <= 1'b1;
                        blank_reg <= 1'b0;
                    end else if (cap_blank) begin
                        val_reg   <= 4'hF;
                        blank_reg <= 1'b1;
                        err_reg   <= 1'b0;
                    end else begin
                        val_reg   <= cap_value;
                        valid_reg <= 1'b1;
                        blank_reg <= 1'b0;
                        err_reg   <= 1'b0;
                    end
                end
            end

            assign digits[4*gi +: 4] = val_reg;
            assign digit_valid[gi]   = valid_reg;
            assign digit_blank[gi]   = blank_reg;
            assign digit_err[gi]     = err_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_stb <= 1'b0;
            err_stb <= 1'b0;
            upd_idx <= 3'd0;
        end else begin
            upd_stb <= capture;
            err_stb <= capture && cap_illegal;
            if (capture)
                upd_idx <= cap_idx;
        end
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: table of display windows with a capture scoreboard,
// plus a hand-written reset-during-count sequence.
module tb_seg7_scan_decoder;
    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
    logic [ND-1:0] dig_en_n;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] digit_valid, digit_blank, digit_err;
    logic          upd_stb, err_stb;
    logic [2:0]    upd_idx;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n),
        .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
        .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g),
        .dig_en_n(dig_en_n), .digits(digits), .digit_valid(digit_valid),
        .digit_blank(digit_blank), .digit_err(digit_err),
        .upd_stb(upd_stb), .upd_idx(upd_idx), .err_stb(err_stb)
    );

    typedef struct {
        logic [3:0]  en_n;
        logic [6:0]  lit;
        int          hold;
        bit          cap;
        logic [2:0]  cidx;
        bit          cerr;
        logic [15:0] exp_digits;
        logic [3:0]  exp_valid;
        logic [3:0]  exp_blank;
        logic [3:0]  exp_err;
    } vec_t;

    typedef struct {
        logic [2:0] idx;
        bit         err;
        int         due;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic [3:0] en_n, input logic [6:0] lit);
        {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = ~lit;
        dig_en_n = en_n;
    endtask

    task automatic check_regs(input string tag, input logic [15:0] d, input logic [3:0] v,
                              input logic [3:0] b, input logic [3:0] e);
        check({tag, ".digits"}, 32'(digits), 32'(d));
        check({tag, ".valid"}, 32'(digit_valid), 32'(v));
        check({tag, ".blank"}, 32'(digit_blank), 32'(b));
        check({tag, ".err"}, 32'(digit_err), 32'(e));
    endtask

    // Scoreboard consumer: every upd_stb must match the oldest pending capture.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && upd_stb) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_upd: got upd_stb idx=%0d at cyc %0d want no capture", upd_idx, cyc);
            end else begin
                e = sb.pop_front();
                $display("capture idx=%0d err_stb=%0b cyc=%0d", upd_idx, err_stb, cyc);
                check("upd_idx", 32'(upd_idx), 32'(e.idx));
                check("err_stb", 32'(err_stb), 32'(e.err));
                check("upd_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        int c;
        drive(4'hF, 7'b0000000);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_regs("reset", 16'hFFFF, 4'h0, 4'h0, 4'h0);
        check("reset.upd_stb", 32'(upd_stb), 32'd0);
        check("reset.err_stb", 32'(err_stb), 32'd0);
        check("reset.upd_idx", 32'(upd_idx), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        vecs[0]  = '{4'b1110, 7'b1111001, 10, 1'b1, 3'd0, 1'b0, 16'hFFF3, 4'b0001, 4'b0000, 4'b0000};
        vecs[1]  = '{4'b1110, 7'b0110000,  8, 1'b1, 3'd0, 1'b0, 16'hFFF1, 4'b0001, 4'b0000, 4'b0000};
        vecs[2]  = '{4'b1101, 7'b1101101,  8, 1'b1, 3'd1, 1'b0, 16'hFF21, 4'b0011, 4'b0000, 4'b0000};
        vecs[3]  = '{4'b1011, 7'b1111110,  8, 1'b1, 3'd2, 1'b0, 16'hF021, 4'b0111, 4'b0000, 4'b0000};
        vecs[4]  = '{4'b0111, 7'b1111011,  8, 1'b1, 3'd3, 1'b0, 16'h9021, 4'b1111, 4'b0000, 4'b0000};
        vecs[5]  = '{4'b1011, 7'b1011011,  3, 1'b0, 3'd0, 1'b0, 16'h9021, 4'b1111, 4'b0000, 4'b0000};
        vecs[6]  = '{4'b1011, 7'b1011111,  8, 1'b1, 3'd2, 1'b0, 16'h9621, 4'b1111, 4'b0000, 4'b0000};
        vecs[7]  = '{4'b1101, 7'b1000001,  8, 1'b1, 3'd1, 1'b1, 16'h9621, 4'b1111, 4'b0000, 4'b0010};
        vecs[8]  = '{4'b1100, 7'b1111111, 20, 1'b0, 3'd0, 1'b0, 16'h9621, 4'b1111, 4'b0000, 4'b0010};
        vecs[9]  = '{4'b0111, 7'b0000000,  8, 1'b1, 3'd3, 1'b0, 16'hF621, 4'b1111, 4'b1000, 4'b0010};
        vecs[10] = '{4'b1111, 7'b0000000,  4, 1'b0, 3'd0, 1'b0, 16'hF621, 4'b1111, 4'b1000, 4'b0010};
        vecs[11] = '{4'b0111, 7'b0000000,  8, 1'b1, 3'd3, 1'b0, 16'hF621, 4'b1111, 4'b1000, 4'b0010};

        for (int i = 0; i < 12; i++) begin
            exp_t e;
            c = cyc;
            drive(vecs[i].en_n, vecs[i].lit);
            if (vecs[i].cap) begin
                e.idx = vecs[i].cidx;
                e.err = vecs[i].cerr;
                e.due = c + SC + 3;
                sb.push_back(e);
            end
            $display("vec %0d en_n=%b lit=%b hold=%0d expect_capture=%0b", i, vecs[i].en_n,
                     vecs[i].lit, vecs[i].hold, vecs[i].cap);
            repeat (vecs[i].hold) @(posedge clk);
            #1;
            check_regs($sformatf("vec%0d", i), vecs[i].exp_digits, vecs[i].exp_valid,
                       vecs[i].exp_blank, vecs[i].exp_err);
            check($sformatf("vec%0d.pending", i), 32'(sb.size()), 32'd0);
            @(negedge clk);
        end

        // Reset while cnt = 3 on a fresh "7" window at position 0.
        drive(4'b1110, 7'b1110000);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_regs("midrst", 16'hFFFF, 4'h0, 4'h0, 4'h0);
        check("midrst.upd_stb", 32'(upd_stb), 32'd0);
        check("midrst.upd_idx", 32'(upd_idx), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        begin
            exp_t e;
            c = cyc;
            rst_n = 1'b1;
            e.idx = 3'd0;
            e.err = 1'b0;
            e.due = c + SC + 3;
            sb.push_back(e);
        end
        $display("reset released, window restarts at cyc %0d", c);
        repeat (SC + 2) @(posedge clk);
        #1;
        check("postrst.early_upd", 32'(upd_stb), 32'd0);
        check("postrst.early_digits", 32'(digits), 32'hFFFF);
        @(posedge clk);
        #1;
        check("postrst.upd_stb", 32'(upd_stb), 32'd1);
        check_regs("postrst", 16'hFFF7, 4'b0001, 4'b0000, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        check("postrst.upd_clear", 32'(upd_stb), 32'd0);
        check("postrst.pending", 32'(sb.size()), 32'd0);

        drive(4'hF, 7'b0000000);
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
